// File: rtl/v_rom_sequencer_pkg.sv
// Shared opcodes, jump conditions, microword field positions and FSM state encoding
// for the ROM microcode sequencer.
package v_rom_sequencer_pkg;

    localparam logic [3:0] OP_OUT  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_WAIT = 4'h4;
    localparam logic [3:0] OP_LDC  = 4'h8;

    localparam logic [1:0] JC_ALWAYS = 2'd0;
    localparam logic [1:0] JC_CNT    = 2'd1;
    localparam logic [1:0] JC_FLAG   = 2'd2;
    localparam logic [1:0] JC_NFLAG  = 2'd3;

    // Microword layout: [19:16] reserved, [15:12] opcode, [11:8] A, [7:0] imm
    localparam int RSVD_LSB = 16;
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int A_MSB    = 11;
    localparam int A_LSB    = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WAIT,
        OUTP
    } state_t;

endpackage

// File: rtl/v_rom_sequencer.sv
// Microcode sequencer: fetches from a registered-address ROM and executes OUT/JMP/WAIT/LDC;
// 2 cycles per plain instruction, first fetch 1 cycle after start; OUT holds out_valid until out_ready.
module v_rom_sequencer
    import v_rom_sequencer_pkg::*;
#(
    parameter int AW = 6,
    parameter int DW = 20,
    parameter int OW = 12,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          stop,
    input  logic          in_flag,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt, pc_inc;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] wcnt, wcnt_nxt;
    logic [OW-1:0] out_data_nxt;
    logic          out_valid_nxt;
    logic          jmp_taken;

    logic [3:0] opcode;
    logic [3:0] fld_a;
    logic [7:0] imm;
    logic       unused_bits;

    assign opcode      = rom_data[OPC_MSB:OPC_LSB];
    assign fld_a       = rom_data[A_MSB:A_LSB];
    assign imm         = rom_data[IMM_MSB:IMM_LSB];
    assign unused_bits = &{1'b0, rom_data[DW-1:RSVD_LSB], fld_a[3:2]};

    assign pc_inc   = pc + AW'(1);
    assign rom_addr = pc;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            cnt       <= cnt_nxt;
            wcnt      <= wcnt_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        cnt_nxt       = cnt;
        wcnt_nxt      = wcnt;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        rom_en        = 1'b0;
        jmp_taken     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    pc_nxt    = start_addr;
                    state_nxt = FETCH;
                end
            end

            // stop is honoured only here, so OUT and WAIT always run to completion
            FETCH: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    rom_en    = 1'b1;
                    state_nxt = EXEC;
                end
            end

            EXEC: begin
                state_nxt = FETCH;
                case (opcode)
                    OP_OUT: begin
                        out_data_nxt  = rom_data[OW-1:0];
                        out_valid_nxt = 1'b1;
                        state_nxt     = OUTP;
                    end
                    OP_JMP: begin
                        case (fld_a[1:0])
                            JC_ALWAYS: jmp_taken = 1'b1;
                            JC_CNT: begin
                                if (cnt != '0) begin
                                    jmp_taken = 1'b1;
                                    cnt_nxt   = cnt - CW'(1);
                                end
                            end
                            JC_FLAG:  jmp_taken = in_flag;
                            JC_NFLAG: jmp_taken = !in_flag;
                            default:  jmp_taken = 1'b0;
                        endcase
                        pc_nxt = jmp_taken ? imm[AW-1:0] : pc_inc;
                    end
                    OP_WAIT: begin
                        if (imm == 8'd0) begin
                            pc_nxt = pc_inc;
                        end else begin
                            // imm-1 so that the WAIT state lasts exactly imm cycles
                            wcnt_nxt  = CW'(imm) - CW'(1);
                            state_nxt = WAIT;
                        end
                    end
                    OP_LDC: begin
                        cnt_nxt = CW'(imm);
                        pc_nxt  = pc_inc;
                    end
                    default: pc_nxt = pc_inc;
                endcase
            end

            WAIT: begin
                if (wcnt == '0) begin
                    pc_nxt    = pc_inc;
                    state_nxt = FETCH;
                end else begin
                    wcnt_nxt = wcnt - CW'(1);
                end
            end

            OUTP: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    pc_nxt        = pc_inc;
                    state_nxt     = FETCH;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_v_rom_sequencer.sv
// Directed bench for v_rom_sequencer with a 1-cycle registered-address ROM model.
module tb_v_rom_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  start_addr;
    logic        stop;
    logic        in_flag;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [19:0] rom_data;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    v_rom_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .in_flag    (in_flag),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    // ROM: address registered on rom_en, data read asynchronously
    logic [19:0] rom [64];
    logic [5:0]  addr_q = 6'd0;
    always @(posedge clk) if (rom_en) addr_q <= rom_addr;
    assign rom_data = rom[addr_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0]  fetch_q[$];
    int          fetch_cyc_q[$];
    logic [11:0] out_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rom_en === 1'b1) begin
                fetch_q.push_back(rom_addr);
                fetch_cyc_q.push_back(cyc);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) out_q.push_back(out_data);
        end
    end

    int checks = 0;
    int errors = 0;
    int st_cyc;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        fetch_q.delete();
        fetch_cyc_q.delete();
        out_q.delete();
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1; in_flag = 1'b0;
        start_addr = 6'd0;
        tick; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 20'h01000;
        clear_logs();
        tick;
    endtask

    task automatic start_at(input logic [5:0] a);
        start_addr = a;
        start = 1'b1;
        st_cyc = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic halt;
        int n;
        stop = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_timeout: busy=%b, expected 0", busy);
        end
        stop = 1'b0;
    endtask

    // Start at a, let one instruction execute, and report the following fetch.
    task automatic step_one(input logic [5:0] a, output logic [5:0] nxt, output logic en);
        start_at(a);
        tick;
        tick;
        nxt = rom_addr;
        en = rom_en;
        halt();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0; in_flag = 1'b0;
        start_addr = 6'd0;
        for (int i = 0; i < 64; i++) rom[i] = 20'h01000;
        repeat (3) tick;
        checks++;
        if ({rom_en, out_valid, busy, rom_addr, out_data} !== 21'd0) begin
            errors++;
            $display("FAIL reset_values: en=%b vld=%b busy=%b addr=%h data=%h, expected all 0",
                     rom_en, out_valid, busy, rom_addr, out_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            checks++;
            if (rom_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: en=%b vld=%b busy=%b, expected 0 0 0",
                         i, rom_en, out_valid, busy);
            end
        end
    endtask

    task automatic test_straight_line;
        do_reset();
        rom[5] = 20'h00ABC;
        rom[6] = 20'h00123;
        start_at(6'd5);
        repeat (7) tick;
        halt();
        checks++;
        if (out_q.size() != 2 || out_q[0] !== 12'hABC || out_q[1] !== 12'h123) begin
            errors++;
            $display("FAIL straight_out: got %0d words first=%h second=%h, expected 2 words abc 123",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 12'hx, out_q.size() > 1 ? out_q[1] : 12'hx);
        end
        checks++;
        if (fetch_q.size() != 3 || fetch_q[0] !== 6'd5 || fetch_q[1] !== 6'd6 || fetch_q[2] !== 6'd7) begin
            errors++;
            $display("FAIL straight_addr: got %0d fetches, expected addresses 5,6,7", fetch_q.size());
        end
        checks++;
        if (fetch_cyc_q.size() == 0 || fetch_cyc_q[0] != st_cyc + 1) begin
            errors++;
            $display("FAIL start_latency: first fetch cycle %0d, expected %0d",
                     fetch_cyc_q.size() > 0 ? fetch_cyc_q[0] : -1, st_cyc + 1);
        end
    endtask

    task automatic test_loop;
        logic [5:0] exp_f [10];
        exp_f = '{6'd0, 6'd1, 6'd2, 6'd1, 6'd2, 6'd1, 6'd2, 6'd1, 6'd2, 6'd3};
        do_reset();
        rom[0] = 20'h08003;
        rom[1] = 20'h00001;
        rom[2] = 20'h02101;
        start_at(6'd0);
        repeat (30) tick;
        halt();
        checks++;
        if (out_q.size() != 4) begin
            errors++;
            $display("FAIL loop_count: got %0d words, expected 4", out_q.size());
        end
        foreach (out_q[i]) begin
            checks++;
            if (out_q[i] !== 12'h001) begin
                errors++;
                $display("FAIL loop_word %0d: got %h, expected 001", i, out_q[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= fetch_q.size() || fetch_q[i] !== exp_f[i]) begin
                errors++;
                $display("FAIL loop_fetch %0d: got %h, expected %h",
                         i, i < fetch_q.size() ? fetch_q[i] : 6'hx, exp_f[i]);
            end
        end
    endtask

    task automatic test_wait_backpressure;
        do_reset();
        rom[10] = 20'h04005;
        rom[20] = 20'h04000;
        rom[30] = 20'h00555;
        start_at(6'd10);
        repeat (12) tick;
        halt();
        checks++;
        if (fetch_q.size() < 2 || fetch_q[1] !== 6'd11 || fetch_cyc_q[1] - fetch_cyc_q[0] != 7) begin
            errors++;
            $display("FAIL wait5: next fetch addr=%h gap=%0d, expected addr 0b gap 7",
                     fetch_q.size() > 1 ? fetch_q[1] : 6'hx,
                     fetch_q.size() > 1 ? fetch_cyc_q[1] - fetch_cyc_q[0] : -1);
        end
        clear_logs();
        start_at(6'd20);
        repeat (4) tick;
        halt();
        checks++;
        if (fetch_q.size() < 2 || fetch_q[1] !== 6'd21 || fetch_cyc_q[1] - fetch_cyc_q[0] != 2) begin
            errors++;
            $display("FAIL wait0: next fetch addr=%h gap=%0d, expected addr 15 gap 2",
                     fetch_q.size() > 1 ? fetch_q[1] : 6'hx,
                     fetch_q.size() > 1 ? fetch_cyc_q[1] - fetch_cyc_q[0] : -1);
        end
        out_ready = 1'b0;
        start_at(6'd30);
        tick;
        tick;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'h555 || rom_addr !== 6'd30 || rom_en !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: vld=%b data=%h addr=%h en=%b, expected 1 555 1e 0",
                         i, out_valid, out_data, rom_addr, rom_en);
            end
            tick;
        end
        out_ready = 1'b1;
        tick;
        checks++;
        if (out_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 6'd31) begin
            errors++;
            $display("FAIL accept: vld=%b en=%b addr=%h, expected 0 1 1f", out_valid, rom_en, rom_addr);
        end
        halt();
    endtask

    task automatic test_flag_jump_wrap;
        logic [5:0] nxt;
        logic       en;
        do_reset();
        rom[40] = 20'h02210;
        rom[42] = 20'h02310;
        rom[44] = 20'h02005;
        in_flag = 1'b1;
        step_one(6'd40, nxt, en);
        checks++;
        if (nxt !== 6'd16 || en !== 1'b1) begin
            errors++;
            $display("FAIL jmp_flag1: next=%h en=%b, expected 10 1", nxt, en);
        end
        in_flag = 1'b0;
        step_one(6'd40, nxt, en);
        checks++;
        if (nxt !== 6'd41 || en !== 1'b1) begin
            errors++;
            $display("FAIL jmp_flag0: next=%h en=%b, expected 29 1", nxt, en);
        end
        step_one(6'd42, nxt, en);
        checks++;
        if (nxt !== 6'd16) begin
            errors++;
            $display("FAIL jmp_nflag: next=%h, expected 10", nxt);
        end
        step_one(6'd44, nxt, en);
        checks++;
        if (nxt !== 6'd5) begin
            errors++;
            $display("FAIL jmp_always: next=%h, expected 05", nxt);
        end
        step_one(6'd63, nxt, en);
        checks++;
        if (nxt !== 6'd0 || en !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: next=%h en=%b, expected 00 1", nxt, en);
        end
    endtask

    task automatic test_stop_reset_start;
        do_reset();
        rom[50] = 20'h00777;
        rom[52] = 20'h04020;
        rom[54] = 20'h04010;
        out_ready = 1'b0;
        start_at(6'd50);
        tick;
        tick;
        stop = 1'b1;
        repeat (3) tick;
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 12'h777) begin
            errors++;
            $display("FAIL stop_in_outp: vld=%b busy=%b data=%h, expected 1 1 777", out_valid, busy, out_data);
        end
        out_ready = 1'b1;
        tick;
        checks++;
        if (out_valid !== 1'b0 || rom_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_fetch: vld=%b en=%b busy=%b, expected 0 0 1", out_valid, rom_en, busy);
        end
        tick;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_q.size() != 1 || fetch_q.size() != 1) begin
            errors++;
            $display("FAIL stop_idle: busy=%b outs=%0d fetches=%0d, expected 0 1 1",
                     busy, out_q.size(), fetch_q.size());
        end

        start_at(6'd52);
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, out_valid, busy, rom_addr, out_data} !== 21'd0) begin
            errors++;
            $display("FAIL reset_in_wait: en=%b vld=%b busy=%b addr=%h data=%h, expected all 0",
                     rom_en, out_valid, busy, rom_addr, out_data);
        end
        tick;
        rst_n = 1'b1;
        tick;

        clear_logs();
        start_at(6'd54);
        tick;
        tick;
        start_addr = 6'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (22) tick;
        halt();
        checks++;
        if (fetch_q.size() < 2 || fetch_q[0] !== 6'd54 || fetch_q[1] !== 6'd55) begin
            errors++;
            $display("FAIL start_while_busy: fetches %h,%h, expected 36,37",
                     fetch_q.size() > 0 ? fetch_q[0] : 6'hx, fetch_q.size() > 1 ? fetch_q[1] : 6'hx);
        end

        clear_logs();
        start_addr = 6'd9;
        start = 1'b1;
        stop = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_en !== 1'b0 || rom_addr !== 6'd9) begin
            errors++;
            $display("FAIL start_stop_fetch: busy=%b en=%b addr=%h, expected 1 0 09", busy, rom_en, rom_addr);
        end
        tick;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || fetch_q.size() != 0) begin
            errors++;
            $display("FAIL start_stop_idle: busy=%b fetches=%0d, expected 0 0", busy, fetch_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_loop();
        test_wait_backpressure();
        test_flag_jump_wrap();
        test_stop_reset_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
